p_rom_loader: RTL and testbench

Program-memory loader: the write side of the processor's program ROM interface. Receives a length-prefixed byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words and writes them into the instruction memory at consecutive word addresses (A, A+4, …), the same byte addressing the fetch side reads with. Sits between the host byte link (UART receiver) and the instruction memory write port; the processor is held off while `busy` is high.

---
 rtl/p_rom_loader_pkg.sv | 18 +
 rtl/p_rom_loader_byte_assembler.sv | 32 +++
 rtl/p_rom_loader.sv | 183 ++++++++++++++++++
 tb/tb_p_rom_loader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/p_rom_loader_pkg.sv
// Shared types and constants for the program-ROM loader.
package p_rom_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned HDR_BYTES  = 2;
  localparam logic [31:0] ADDR_STEP  = 32'd4;

endpackage

// File: rtl/p_rom_loader_byte_assembler.sv
// Collects four stream bytes LSB-first into a 32-bit instruction word.
module byte_assembler
  import p_rom_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear,
  input  logic        i_push,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_done
);

  logic [1:0]  r_idx;
  logic [23:0] r_sr;

  // Only the three earlier bytes are stored; the completing byte is
  // combined on the fly so the loader can register the whole word at once.
  assign o_word      = {i_byte, r_sr};
  assign o_word_done = i_push && (r_idx == 2'(WORD_BYTES - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_idx <= '0;
      r_sr  <= '0;
    end else if (i_push) begin
      r_idx <= r_idx + 2'd1;
      r_sr  <= {i_byte, r_sr[23:8]};
    end
  end

endmodule

// File: rtl/p_rom_loader.sv
// Program-ROM loader: length-prefixed byte stream to instruction memory writes.
// Optional trailing XOR checksum byte when P_ROM_LOADER_CHECKSUM_EN is defined.
module p_rom_loader
  import p_rom_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  state_t      r_state;
  logic        r_byte_ready;
  logic        r_busy;
  logic        r_done;
  logic        r_error;
  logic        r_mem_we;
  logic [31:0] r_mem_a;
  logic [31:0] r_mem_wd;
  logic [15:0] r_word_count;
  logic [15:0] r_n;
  logic [7:0]  r_hdr_lo;
  logic        r_hdr_idx;
`ifdef P_ROM_LOADER_CHECKSUM_EN
  logic [7:0]  r_csum;
`endif

  logic        w_xfer;
  logic        w_idle_like;
  logic        w_clear;
  logic        w_push;
  logic        w_word_done;
  logic [31:0] w_word;
  logic [15:0] w_hdr_n;
  logic        w_hdr_bad;
  logic [15:0] w_cnt_next;

  assign w_xfer      = byte_valid && r_byte_ready;
  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR);
  assign w_clear     = start && w_idle_like;
  assign w_push      = w_xfer && (r_state == S_DATA);
  assign w_hdr_n     = {byte_data, r_hdr_lo};
  assign w_hdr_bad   = (w_hdr_n == '0) || (32'(w_hdr_n) > MAX_WORDS);
  assign w_cnt_next  = r_word_count + 16'd1;

  byte_assembler u_asm (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_clear     (w_clear),
    .i_push      (w_push),
    .i_byte      (byte_data),
    .o_word      (w_word),
    .o_word_done (w_word_done)
  );

  // Outputs are registered from the next-state decision so each one changes
  // on the same edge as the state it belongs to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_byte_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_a      <= '0;
      r_mem_wd     <= '0;
      r_word_count <= '0;
      r_n          <= '0;
      r_hdr_lo     <= '0;
      r_hdr_idx    <= 1'b0;
`ifdef P_ROM_LOADER_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            r_state      <= S_HDR;
            r_byte_ready <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_word_count <= '0;
            r_hdr_idx    <= 1'b0;
`ifdef P_ROM_LOADER_CHECKSUM_EN
            r_csum       <= '0;
`endif
          end
        end
        S_HDR: begin
          if (w_xfer) begin
            if (r_hdr_idx == 1'(HDR_BYTES - 1)) begin
              r_n <= w_hdr_n;
              if (w_hdr_bad) begin
                r_state      <= S_ERROR;
                r_byte_ready <= 1'b0;
                r_busy       <= 1'b0;
                r_error      <= 1'b1;
              end else begin
                r_state <= S_DATA;
              end
            end else begin
              r_hdr_lo  <= byte_data;
              r_hdr_idx <= 1'b1;
            end
          end
        end
        S_DATA: begin
          if (w_xfer) begin
`ifdef P_ROM_LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ byte_data;
`endif
            if (w_word_done) begin
              r_state      <= S_WRITE;
              r_byte_ready <= 1'b0;
              r_mem_we     <= 1'b1;
              r_mem_a      <= BASE_ADDR + 32'(r_word_count) * ADDR_STEP;
              r_mem_wd     <= w_word;
            end
          end
        end
        S_WRITE: begin
          r_mem_we     <= 1'b0;
          r_mem_a      <= '0;
          r_mem_wd     <= '0;
          r_word_count <= w_cnt_next;
          if (w_cnt_next < r_n) begin
            r_state      <= S_DATA;
            r_byte_ready <= 1'b1;
          end else begin
`ifdef P_ROM_LOADER_CHECKSUM_EN
            r_state      <= S_CHK;
            r_byte_ready <= 1'b1;
`else
            r_state      <= S_DONE;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
`endif
          end
        end
`ifdef P_ROM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (w_xfer) begin
            r_byte_ready <= 1'b0;
            r_busy       <= 1'b0;
            if (byte_data == r_csum) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
            end
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign byte_ready = r_byte_ready;
  assign mem_we     = r_mem_we;
  assign mem_a      = r_mem_a;
  assign mem_wd     = r_mem_wd;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_p_rom_loader.sv
// Scoreboard bench for p_rom_loader; expected writes are queued as words are sent.
module tb_p_rom_loader;

  localparam logic [31:0] TB_BASE = 32'h0000_0100;
`ifdef P_ROM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] word_count;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_writes = 0;
  logic [63:0] q_exp[$];
  logic [31:0] wq[$];
  logic [63:0] m_exp;

  p_rom_loader #(
    .BASE_ADDR (TB_BASE),
    .MAX_WORDS (1024)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write-port monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        n_writes++;
        if (q_exp.size() == 0) begin
          chk("unexpected_write", {mem_a, mem_wd}, 64'h0);
        end else begin
          m_exp = q_exp.pop_front();
          chk("write_addr_data", {mem_a, mem_wd}, m_exp);
        end
      end else begin
        chk("bus_zero_when_idle", {mem_a, mem_wd}, 64'h0);
      end
    end
  end

  function automatic int unsigned stall_of(input int unsigned mode);
    if (mode == 0) return 0;
    if (mode == 1) return 1;
    return $urandom_range(0, 3);
  endfunction

  // Entered and left at a negedge; the transfer happens at the posedge between.
  task automatic send_byte(input logic [7:0] b, input int unsigned stall);
    int unsigned c;
    if (stall > 0) begin
      byte_valid = 1'b0;
      repeat (stall) @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    c = 0;
    while (!byte_ready && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("byte_ready_timeout", 64'(c < 200), 64'h1);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy_ready", {busy, byte_ready, done, error}, 64'b1100);
    chk("start_word_count", 64'(word_count), 64'h0);
  endtask

  task automatic run_load(input int unsigned n, input int unsigned mode,
                          input bit bad_csum, input bit start_mid);
    logic [7:0]  x;
    logic [31:0] w;
    logic [15:0] nh;
    int          wr0;
    int unsigned c;
    bit          exp_err;
    x       = 8'h00;
    nh      = 16'(n);
    wr0     = n_writes;
    exp_err = bad_csum & CSUM_EN;
    pulse_start();
    send_byte(nh[7:0], stall_of(mode));
    send_byte(nh[15:8], stall_of(mode));
    for (int unsigned k = 0; k < n; k++) begin
      w = wq[k];
      q_exp.push_back({TB_BASE + k * 4, w});
      for (int unsigned j = 0; j < 4; j++) begin
        send_byte(w[8*j +: 8], stall_of(mode));
        x = x ^ w[8*j +: 8];
        if (start_mid && k == 0 && j == 1) begin
          byte_valid = 1'b0;
          start      = 1'b1;
          @(negedge clk);
          start = 1'b0;
          chk("start_mid_ignored", {busy, byte_ready, done, error}, 64'b1100);
        end
      end
    end
    if (CSUM_EN) send_byte(bad_csum ? ~x : x, stall_of(mode));
    byte_valid = 1'b0;
    c = 0;
    while (!(done || error) && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("end_latency", 64'(c), CSUM_EN ? 64'd0 : 64'd1);
    chk("end_flags", {busy, byte_ready, done, error}, {2'b00, !exp_err, exp_err});
    chk("end_word_count", 64'(word_count), 64'(n));
    chk("end_write_count", 64'(n_writes - wr0), 64'(n));
    chk("scoreboard_empty", 64'(q_exp.size()), 64'h0);
  endtask

  task automatic hdr_err(input logic [7:0] b0, input logic [7:0] b1);
    int wr0;
    wr0 = n_writes;
    pulse_start();
    send_byte(b0, 0);
    send_byte(b1, 0);
    byte_valid = 1'b0;
    chk("hdr_err_flags", {busy, byte_ready, done, error}, 64'b0001);
    repeat (3) @(negedge clk);
    chk("hdr_err_no_write", 64'(n_writes - wr0), 64'h0);
  endtask

  initial begin
    int wr0;
    int unsigned wc;
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_flags", {byte_ready, mem_we, busy, done, error}, 64'h0);
    chk("reset_bus", {mem_a, mem_wd}, 64'h0);
    chk("reset_word_count", 64'(word_count), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic two-word program, back-to-back bytes.
    wq = {32'h0000_0013, 32'h0010_0093};
    run_load(2, 0, 1'b0, 1'b0);

    // A byte offered in DONE must not be consumed.
    wc = 32'(word_count);
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    repeat (4) @(negedge clk);
    byte_valid = 1'b0;
    chk("done_hold_flags", {busy, byte_ready, done, error}, 64'b0010);
    chk("done_hold_count", 64'(word_count), 64'(wc));

    // Same stream with toggling valid, then random stalls.
    run_load(2, 1, 1'b0, 1'b0);
    run_load(2, 2, 1'b0, 1'b0);

    // Header failures: zero length and one past MAX_WORDS.
    hdr_err(8'h00, 8'h00);
    hdr_err(8'h01, 8'h04);

    // start during DATA is ignored; single word lands at BASE_ADDR.
    wq = {32'hCAFE_F00D};
    run_load(1, 0, 1'b0, 1'b1);

    // Random multi-word load.
    wq = {};
    for (int i = 0; i < 5; i++) wq.push_back($urandom);
    run_load(5, 2, 1'b0, 1'b0);

    // Reset after six data bytes of an N=2 load.
    wr0 = n_writes;
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    q_exp.push_back({TB_BASE, 32'h1122_3344});
    send_byte(8'h44, 0);
    send_byte(8'h33, 0);
    send_byte(8'h22, 0);
    send_byte(8'h11, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    byte_valid = 1'b0;
    rst_n      = 1'b0;
    @(negedge clk);
    chk("midreset_flags", {byte_ready, mem_we, busy, done, error}, 64'h0);
    chk("midreset_bus", {mem_a, mem_wd}, 64'h0);
    chk("midreset_word_count", 64'(word_count), 64'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midreset_writes", 64'(n_writes - wr0), 64'h1);

    wq = {32'hDEAD_BEEF};
    run_load(1, 0, 1'b0, 1'b0);

    // Checksum variants; without the feature these behave as plain loads.
    wq = {32'h0804_0201};
    run_load(1, 0, 1'b0, 1'b0);
    run_load(1, 0, 1'b1, 1'b0);

    // Largest legal program.
    wq = {};
    for (int i = 0; i < 1024; i++) wq.push_back(32'(i) * 32'h0101_0001);
    run_load(1024, 0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
